// File: rtl/snake_food_gen.sv
// Food cell generator for the snake game: random pick from an LFSR, occupancy
// check against the snake body, row-major scan fallback and full-grid flag.
module snake_food_gen #(
  parameter int unsigned GRID_W    = 40,
  parameter int unsigned GRID_H    = 30,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_TRIES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  output logic       occ_req,
  output logic [5:0] occ_x,
  output logic [4:0] occ_y,
  input  logic       occ_hit,
  output logic [5:0] food_x,
  output logic [4:0] food_y,
  output logic       food_valid,
  output logic       busy,
  output logic       grid_full
);

  localparam logic [5:0] X_LAST    = 6'(GRID_W - 1);
  localparam logic [4:0] Y_LAST    = 5'(GRID_H - 1);
  localparam logic [7:0] TRY_LIMIT = 8'(MAX_TRIES);

  typedef enum logic [2:0] {IDLE, PICK, WAIT, CHECK, SCAN} state_t;

  state_t      state, state_nxt;
  logic [15:0] lfsr, lfsr_nxt;
  logic [7:0]  tries, tries_nxt;
  logic        scan_mode, scan_mode_nxt;
  logic [5:0]  scan_x, scan_x_nxt;
  logic [4:0]  scan_y, scan_y_nxt;
  logic        occ_req_nxt;
  logic [5:0]  occ_x_nxt, food_x_nxt;
  logic [4:0]  occ_y_nxt, food_y_nxt;
  logic        food_valid_nxt, busy_nxt, grid_full_nxt;

  logic [5:0] cand_x;
  logic [4:0] cand_y;
  logic       cand_ok;

  assign cand_x  = lfsr[5:0];
  assign cand_y  = lfsr[10:6];
  assign cand_ok = (cand_x <= X_LAST) && (cand_y <= Y_LAST);

  // Taps 16,14,13,11; the generator free-runs in every state.
  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    state_nxt      = state;
    tries_nxt      = tries;
    scan_mode_nxt  = scan_mode;
    scan_x_nxt     = scan_x;
    scan_y_nxt     = scan_y;
    occ_req_nxt    = 1'b0;
    occ_x_nxt      = occ_x;
    occ_y_nxt      = occ_y;
    food_x_nxt     = food_x;
    food_y_nxt     = food_y;
    food_valid_nxt = food_valid;
    busy_nxt       = busy;
    grid_full_nxt  = grid_full;

    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt      = PICK;
          busy_nxt       = 1'b1;
          food_valid_nxt = 1'b0;
          grid_full_nxt  = 1'b0;
          tries_nxt      = '0;
          scan_mode_nxt  = 1'b0;
        end
      end
      PICK: begin
        if (tries >= TRY_LIMIT) begin
          state_nxt     = SCAN;
          scan_mode_nxt = 1'b1;
          scan_x_nxt    = '0;
          scan_y_nxt    = '0;
        end else if (!cand_ok) begin
          tries_nxt = tries + 8'd1;
        end else begin
          occ_x_nxt   = cand_x;
          occ_y_nxt   = cand_y;
          occ_req_nxt = 1'b1;
          state_nxt   = WAIT;
        end
      end
      WAIT: state_nxt = CHECK;
      CHECK: begin
        if (!occ_hit) begin
          food_x_nxt     = occ_x;
          food_y_nxt     = occ_y;
          food_valid_nxt = 1'b1;
          busy_nxt       = 1'b0;
          state_nxt      = IDLE;
        end else if (!scan_mode) begin
          tries_nxt = tries + 8'd1;
          state_nxt = PICK;
        end else if (scan_x != X_LAST) begin
          scan_x_nxt = scan_x + 6'd1;
          state_nxt  = SCAN;
        end else if (scan_y != Y_LAST) begin
          scan_x_nxt = '0;
          scan_y_nxt = scan_y + 5'd1;
          state_nxt  = SCAN;
        end else begin
          // Every cell is body: the win condition for the game.
          grid_full_nxt  = 1'b1;
          food_valid_nxt = 1'b0;
          busy_nxt       = 1'b0;
          state_nxt      = IDLE;
        end
      end
      SCAN: begin
        occ_x_nxt   = scan_x;
        occ_y_nxt   = scan_y;
        occ_req_nxt = 1'b1;
        state_nxt   = WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lfsr       <= SEED;
      tries      <= '0;
      scan_mode  <= 1'b0;
      scan_x     <= '0;
      scan_y     <= '0;
      occ_req    <= 1'b0;
      occ_x      <= '0;
      occ_y      <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      busy       <= 1'b0;
      grid_full  <= 1'b0;
    end else begin
      state      <= state_nxt;
      lfsr       <= lfsr_nxt;
      tries      <= tries_nxt;
      scan_mode  <= scan_mode_nxt;
      scan_x     <= scan_x_nxt;
      scan_y     <= scan_y_nxt;
      occ_req    <= occ_req_nxt;
      occ_x      <= occ_x_nxt;
      occ_y      <= occ_y_nxt;
      food_x     <= food_x_nxt;
      food_y     <= food_y_nxt;
      food_valid <= food_valid_nxt;
      busy       <= busy_nxt;
      grid_full  <= grid_full_nxt;
    end
  end

endmodule

// File: tb/tb_snake_food_gen.sv
// Bench for snake_food_gen: occupancy map model, per-search prediction of
// query sequence, latency and result, plus an LFSR tracker checked every cycle.
module tb_snake_food_gen;

  localparam int          GW   = 40;
  localparam int          GH   = 30;
  localparam int          MT   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst, req, occ_hit;
  logic       occ_req, food_valid, busy, grid_full;
  logic [5:0] occ_x, food_x;
  logic [4:0] occ_y, food_y;

  always #5 clk = ~clk;

  snake_food_gen #(.GRID_W(GW), .GRID_H(GH), .SEED(SEED), .MAX_TRIES(MT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .busy(busy), .grid_full(grid_full)
  );

  bit          occ_map [GW][GH];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] m_lfsr;
  logic [5:0]  m_fx = '0;
  logic [4:0]  m_fy = '0;
  logic        prev_req = 1'b0;
  logic [5:0]  prev_x = '0;
  logic [4:0]  prev_y = '0;
  int          strobes;
  logic [10:0] act_q[$];
  logic [10:0] exp_q[$];
  int          exp_cyc;
  bit          exp_full;
  logic [5:0]  exp_fx;
  logic [4:0]  exp_fy;

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic fill_map(input int pct_hit);
    for (int x = 0; x < GW; x++)
      for (int y = 0; y < GH; y++)
        occ_map[x][y] = ($urandom_range(0, 99) < pct_hit);
  endtask

  // One clock: track the LFSR, answer the previous cycle's query, log strobes.
  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    m_lfsr = r ? SEED : step(m_lfsr);
    #1;
    if (r) prev_req = 1'b0;
    occ_hit  = prev_req ? occ_map[prev_x][prev_y] : 1'($urandom_range(0, 1));
    prev_req = occ_req;
    prev_x   = occ_x;
    prev_y   = occ_y;
    if (occ_req) begin
      strobes++;
      act_q.push_back({occ_x, occ_y});
    end
    check("lfsr", 32'(dut.lfsr), 32'(m_lfsr));
  endtask

  // Walk the search rules as a list of attempts with their cycle costs.
  task automatic predict(input logic [15:0] start);
    logic [15:0] l;
    int          tries;
    bit          found;
    logic [5:0]  cx;
    logic [4:0]  cy;
    l = start; tries = 0; found = 0;
    exp_q.delete();
    exp_cyc = 0; exp_full = 0; exp_fx = m_fx; exp_fy = m_fy;
    while (!found && tries < MT) begin
      cx = l[5:0];
      cy = l[10:6];
      if (int'(cx) >= GW || int'(cy) >= GH) begin
        tries++; exp_cyc += 1; l = step(l);
      end else begin
        exp_q.push_back({cx, cy});
        exp_cyc += 3; l = step(step(step(l)));
        if (!occ_map[cx][cy]) begin
          found = 1; exp_fx = cx; exp_fy = cy;
        end else tries++;
      end
    end
    if (!found) begin
      exp_cyc += 1;
      for (int y = 0; y < GH; y++)
        for (int x = 0; x < GW; x++)
          if (!found) begin
            exp_q.push_back({6'(x), 5'(y)});
            exp_cyc += 3;
            if (!occ_map[x][y]) begin
              found = 1; exp_fx = 6'(x); exp_fy = 5'(y);
            end
          end
      if (!found) exp_full = 1;
    end
  endtask

  task automatic do_search(input bit hold_req);
    int n;
    int mism;
    strobes = 0;
    act_q.delete();
    req = 1'b1;
    tick();
    if (!hold_req) req = 1'b0;
    predict(m_lfsr);
    check("busy_after_req", 32'(busy), 32'd1);
    check("valid_cleared", 32'(food_valid), 32'd0);
    check("full_cleared", 32'(grid_full), 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 6000) begin
      tick();
      n++;
    end
    req = 1'b0;
    check("latency", 32'(n), 32'(exp_cyc));
    check("grid_full", 32'(grid_full), 32'(exp_full));
    check("food_valid", 32'(food_valid), 32'(!exp_full));
    check("food_x", 32'(food_x), 32'(exp_fx));
    check("food_y", 32'(food_y), 32'(exp_fy));
    check("food_in_range", 32'(int'(food_x) < GW && int'(food_y) < GH), 32'd1);
    check("strobes", 32'(strobes), 32'(exp_q.size()));
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      if (act_q[i] !== exp_q[i]) mism++;
    check("query_seq", 32'(mism), 32'd0);
    m_fx = exp_fx;
    m_fy = exp_fy;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_occ_req"}, 32'(occ_req), 32'd0);
    check({tag, "_occ_x"}, 32'(occ_x), 32'd0);
    check({tag, "_occ_y"}, 32'(occ_y), 32'd0);
    check({tag, "_food_x"}, 32'(food_x), 32'd0);
    check({tag, "_food_y"}, 32'(food_y), 32'd0);
    check({tag, "_food_valid"}, 32'(food_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_grid_full"}, 32'(grid_full), 32'd0);
  endtask

  initial begin
    int guard;
    rst = 1'b1; req = 1'b0; occ_hit = 1'b0;
    m_lfsr = SEED;
    fill_map(0);
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // Free grid, random gaps between requests.
    for (int i = 0; i < 4; i++) begin
      do_search(1'b0);
      for (int g = $urandom_range(0, 5); g > 0; g--) tick();
    end

    // Only (7,3) free: random attempts exhaust, scan finds it.
    fill_map(100);
    occ_map[7][3] = 1'b0;
    do_search(1'b0);
    tick();

    // Random crowded boards.
    for (int i = 0; i < 3; i++) begin
      fill_map(70);
      do_search(1'b0);
      tick();
    end

    // Completely full board, then a request on a free board clears the flag.
    fill_map(100);
    do_search(1'b0);
    tick();
    check("full_sticky", 32'(grid_full), 32'd1);
    fill_map(0);
    do_search(1'b0);

    // Requests held high through a search start only one search.
    tick();
    do_search(1'b1);
    tick();
    tick();
    check("no_second_search", 32'(busy), 32'd0);

    // Reset while waiting on an occupancy answer.
    fill_map(30);
    req = 1'b1;
    tick();
    req = 1'b0;
    guard = 0;
    while (occ_req !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    check("reached_wait", 32'(occ_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_fx = '0;
    m_fy = '0;
    check_reset_outputs("midreset");
    tick();
    check("idle_after_reset", 32'(busy), 32'd0);
    do_search(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/snake_food_gen.md
Name: snake_food_gen

Overview:
- Generates the pseudo-random food cell for the snake game, upstream of GameModule.
- On a request (game start or food eaten), it picks a random in-range grid cell and queries GameModule's body-occupancy lookup to confirm the cell is free.
- It then publishes the cell as the new food position.
- If random picking keeps failing, it falls back to a row-major scan. If no cell is free, it flags a full grid, which GameModule uses as the win condition.

Parameters:
- GRID_W, 40, grid columns (640 px / 16 px cells).
- GRID_H, 30, grid rows (480 px / 16 px cells).
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- MAX_TRIES, 64, random attempts before switching to scan; range 1..255.

Ports:
- clk  in  1  system clock, same domain as GameModule
- rst  in  1  synchronous, active-high reset
- req  in  1  single-cycle request for new food; honoured only when busy=0
- occ_req  out  1  single-cycle strobe: occupancy query for occ_x/occ_y
- occ_x  out  6  queried column
- occ_y  out  5  queried row
- occ_hit  in  1  1 = cell occupied by snake; valid exactly one cycle after the occ_req cycle
- food_x  out  6  current food column
- food_y  out  5  current food row
- food_valid  out  1  food_x/food_y hold a verified free cell
- busy  out  1  a search is in progress
- grid_full  out  1  a full scan found no free cell; sticky until the next accepted req or reset

Behaviour:
- Reset (rst=1 at a clk edge): lfsr=SEED; state=IDLE; food_x=0; food_y=0; food_valid=0; busy=0; grid_full=0; occ_req=0; occ_x=0; occ_y=0; tries=0.
- A reset asserted mid-search aborts the search immediately and leaves no partial result.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, feedback shifted in at bit 0.
  - Advances every clk cycle in every state; held only by rst.
  - Candidate cell: x=lfsr[5:0], y=lfsr[10:6].
- All outputs are registered. States are IDLE, PICK, WAIT, CHECK and SCAN.
- IDLE: if req=1, go to PICK with busy=1, food_valid=0, grid_full=0, tries=0. A req while busy=1 is ignored.
- PICK:
  - Candidate out of range (x>=GRID_W or y>=GRID_H): tries+1, stay in PICK.
  - Candidate in range: occ_x/occ_y=candidate, occ_req=1 for one cycle, go to WAIT.
  - If tries reaches MAX_TRIES: go to SCAN with scan cell=(0,0).
- WAIT: occ_req=0, go to CHECK.
- CHECK: sample occ_hit.
  - occ_hit=0: food_x/food_y=occ_x/occ_y, food_valid=1, busy=0, go to IDLE.
  - occ_hit=1 in random mode: tries+1, go to PICK. PICK applies the MAX_TRIES rule before picking again.
  - occ_hit=1 in scan mode: advance the scan cell and return to SCAN.
- Scan order: x increments; when x wraps from GRID_W-1 to 0, y increments.
  - Advancing past (GRID_W-1, GRID_H-1) ends the scan: grid_full=1, food_valid=0, busy=0, go to IDLE. The previous food_x/food_y values are held.
- SCAN: occ_x/occ_y=scan cell, occ_req=1, go to WAIT. Each scanned cell costs 3 cycles.
- Latency: the minimum from the req sample edge to food_valid=1 is 3 edges (PICK, WAIT, CHECK). Each range reject adds 1 cycle; each random hit adds 3.
- Output guarantee: food_x<GRID_W and food_y<GRID_H whenever food_valid=1.
- food_x, food_y and food_valid change only at CHECK success, at req acceptance (food_valid only), at scan exhaustion (food_valid only), or at reset.
- occ_x/occ_y remain stable from the occ_req cycle through CHECK.

Test Plan:
- Reset with rst=1 for 2 cycles -> all outputs 0; lfsr=16'hACE1. After release, lfsr matches a reference LFSR model every cycle.
- occ_hit tied 0, one req pulse -> busy=1 on the next cycle; exactly one occ_req. food_valid=1 at 3 + number-of-range-rejects cycles; food_x/food_y equal the queried cell, and food_x<40, food_y<30.
- Occupancy model returns hit for every cell except (7,3), MAX_TRIES=4 -> 4 random attempts, then scan (0,0),(1,0),… -> food=(7,3), food_valid=1. The scan takes 128 occ_req strobes (3*40+7+1).
- Occupancy model returns hit for all cells -> after the random attempts, 1200 scan queries; then grid_full=1, food_valid=0, busy=0. The next req clears grid_full.
- req pulsed on every cycle while busy=1 -> only one search runs, food_valid rises once, and the occ_req count equals a single-search count.
- rst=1 asserted in WAIT during a search -> the next cycle is IDLE with all outputs at reset values. A new req then completes normally.
